// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer
// Walks every FFT stage span m and index i, issues twiddle ROM addresses and
// streams sign-corrected twiddles tagged with valid, stage span and last-in-stage.
// A mode-dependent start delay lines the stream up with the butterfly pipeline.
module fft_twiddle_sequencer #(
  parameter int LOG_N        = 12,
  parameter int OVERALL_BITS = 32,
  parameter int ROM_RD_LAT   = 2,
  parameter int FWD_DELAY    = 9,
  parameter int INV_DELAY    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      is_forward_fft_i,
  input  logic                      stall_i,
  output logic [LOG_N-1:0]          rom_addr_o,
  input  logic [2*OVERALL_BITS-1:0] rom_data_i,
  output logic [OVERALL_BITS-1:0]   tw_real_o,
  output logic [OVERALL_BITS-1:0]   tw_imag_o,
  output logic                      tw_valid_o,
  output logic [LOG_N:0]            tw_m_o,
  output logic                      tw_last_in_stg_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int N       = 1 << LOG_N;
  localparam int TAG_LAT = ROM_RD_LAT + 1;
  localparam int MAXD    = (FWD_DELAY > INV_DELAY) ? FWD_DELAY : INV_DELAY;
  localparam int DLY_W   = (MAXD > 1) ? $clog2(MAXD + 1) : 1;
  // The delay counter is loaded with D-2 because entering RUN itself takes one edge
  localparam logic [DLY_W-1:0] FWD_LOAD = DLY_W'((FWD_DELAY >= 2) ? FWD_DELAY - 2 : 0);
  localparam logic [DLY_W-1:0] INV_LOAD = DLY_W'((INV_DELAY >= 2) ? INV_DELAY - 2 : 0);

  typedef enum logic [1:0] {IDLE, DELAY, RUN, DRAIN} state_t;

  typedef struct packed {
    logic           valid;
    logic           negRe;
    logic           negIm;
    logic           last;
    logic           fin;
    logic [LOG_N:0] m;
  } tag_t;

  state_t           state_q;
  logic [DLY_W-1:0] dly_q;
  logic             mode_q;
  logic             busy_q;
  logic             done_q;

  logic [LOG_N-1:0] idx_q, idx_d;
  logic [LOG_N:0]   stageM_q, stageM_d;
  logic [LOG_N-1:0] base_q, base_d;
  logic [LOG_N-1:0] romAddr_q;

  tag_t             tagPipe_q [TAG_LAT];
  tag_t             tail;

  logic [OVERALL_BITS-1:0] twReal_q, twImag_q;
  logic                    twValid_q, twLast_q, outFin_q;
  logic [LOG_N:0]          twM_q;

  logic             issue, lastIdx, upperHalf, finalIssue;
  logic [LOG_N:0]   halfM, quarterM;
  logic [LOG_N-1:0] issueAddr;
  logic [OVERALL_BITS-1:0] romRe, romIm;

  assign romRe = rom_data_i[2*OVERALL_BITS-1:OVERALL_BITS];
  assign romIm = rom_data_i[OVERALL_BITS-1:0];
  assign tail  = tagPipe_q[TAG_LAT-1];

  // Decode the current (m, i, base) into address, sign flags and next-counter values
  always_comb begin
    halfM      = stageM_q >> 1;
    quarterM   = stageM_q >> 2;
    issue      = (state_q == RUN) && !stall_i;
    lastIdx    = ({1'b0, idx_q} == (stageM_q - (LOG_N+1)'(1)));
    upperHalf  = ({1'b0, idx_q} >= halfM);
    finalIssue = lastIdx && (mode_q ? (stageM_q == (LOG_N+1)'(N))
                                    : (stageM_q == (LOG_N+1)'(2)));
    if (upperHalf)
      issueAddr = base_q + stageM_q[LOG_N-1:0] - LOG_N'(1) - idx_q;
    else
      issueAddr = base_q + idx_q;

    idx_d    = idx_q;
    stageM_d = stageM_q;
    base_d   = base_q;
    if (state_q == IDLE && start_i) begin
      idx_d    = '0;
      stageM_d = is_forward_fft_i ? (LOG_N+1)'(2) : (LOG_N+1)'(N);
      base_d   = is_forward_fft_i ? '0 : LOG_N'(N/2 - 1);
    end else if (issue) begin
      if (lastIdx) begin
        idx_d = '0;
        if (mode_q) begin
          base_d   = base_q + halfM[LOG_N-1:0];
          stageM_d = stageM_q << 1;
        end else begin
          if (stageM_q > (LOG_N+1)'(2))
            base_d = base_q - quarterM[LOG_N-1:0];
          stageM_d = stageM_q >> 1;
        end
      end else begin
        idx_d = idx_q + LOG_N'(1);
      end
    end
  end

  // Control FSM: start delay, issue phase, drain until the final twiddle has left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      mode_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q <= is_forward_fft_i;
            busy_q <= 1'b1;
            if ((is_forward_fft_i ? FWD_DELAY : INV_DELAY) <= 1) begin
              state_q <= RUN;
            end else begin
              state_q <= DELAY;
              dly_q   <= is_forward_fft_i ? FWD_LOAD : INV_LOAD;
            end
          end
        end
        DELAY: begin
          if (dly_q == '0) state_q <= RUN;
          else             dly_q   <= dly_q - DLY_W'(1);
        end
        RUN: begin
          if (issue && finalIssue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (outFin_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage span, index and base counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      stageM_q <= '0;
      base_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      stageM_q <= stageM_d;
      base_q   <= base_d;
    end
  end

  // ROM address register plus tag pipeline that travels alongside the ROM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      romAddr_q <= '0;
      for (int k = 0; k < TAG_LAT; k++) tagPipe_q[k] <= '0;
    end else begin
      if (issue) begin
        romAddr_q          <= issueAddr;
        tagPipe_q[0].valid <= 1'b1;
        tagPipe_q[0].negRe <= upperHalf;
        tagPipe_q[0].negIm <= ~mode_q;
        tagPipe_q[0].last  <= lastIdx;
        tagPipe_q[0].fin   <= finalIssue;
        tagPipe_q[0].m     <= stageM_q;
      end else begin
        tagPipe_q[0] <= '0;
      end
      for (int k = 1; k < TAG_LAT; k++) tagPipe_q[k] <= tagPipe_q[k-1];
    end
  end

  // Output registers: apply sign corrections, hold last twiddle while not valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      twReal_q  <= '0;
      twImag_q  <= '0;
      twM_q     <= '0;
      twLast_q  <= 1'b0;
      twValid_q <= 1'b0;
      outFin_q  <= 1'b0;
    end else begin
      twValid_q <= tail.valid;
      outFin_q  <= tail.valid & tail.fin;
      if (tail.valid) begin
        twReal_q <= {romRe[OVERALL_BITS-1] ^ tail.negRe, romRe[OVERALL_BITS-2:0]};
        twImag_q <= {romIm[OVERALL_BITS-1] ^ tail.negIm, romIm[OVERALL_BITS-2:0]};
        twM_q    <= tail.m;
        twLast_q <= tail.last;
      end
    end
  end

  // The base register must always equal m/2-1 whenever an address is issued
  always_ff @(posedge clk) begin
    if (!rst && issue)
      assert (base_q == halfM[LOG_N-1:0] - LOG_N'(1));
  end

  assign rom_addr_o       = romAddr_q;
  assign tw_real_o        = twReal_q;
  assign tw_imag_o        = twImag_q;
  assign tw_valid_o       = twValid_q;
  assign tw_m_o           = twM_q;
  assign tw_last_in_stg_o = twLast_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// tb_fft_twiddle_sequencer
// Directed bench for the twiddle sequencer at N=16 with a behavioural ROM
// holding entry k = {float(k), float(-k)}.
module tb_fft_twiddle_sequencer;

  localparam int LOG_N = 4;
  localparam int N     = 16;
  localparam int OB    = 32;
  localparam int LAT   = 2;
  localparam int FWD_D = 9;
  localparam int INV_D = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            isFwd;
  logic            stall;
  logic [LOG_N-1:0] romAddr;
  logic [2*OB-1:0]  romData;
  logic [OB-1:0]    twReal, twImag;
  logic             twValid, twLast, busy, done;
  logic [LOG_N:0]   twM;

  int total = 0;
  int bad   = 0;

  logic [2*OB-1:0] romPipe [LAT];

  fft_twiddle_sequencer #(
    .LOG_N(LOG_N), .OVERALL_BITS(OB), .ROM_RD_LAT(LAT),
    .FWD_DELAY(FWD_D), .INV_DELAY(INV_D)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .is_forward_fft_i(isFwd),
    .stall_i(stall), .rom_addr_o(romAddr), .rom_data_i(romData),
    .tw_real_o(twReal), .tw_imag_o(twImag), .tw_valid_o(twValid),
    .tw_m_o(twM), .tw_last_in_stg_o(twLast), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Single-precision encoding of a small integer, built bit by bit
  function automatic logic [31:0] floatOf(input int v);
    int a;
    int e;
    logic s;
    logic [22:0] man;
    s = (v < 0);
    a = s ? -v : v;
    if (a == 0) return 32'h0000_0000;
    e = 0;
    while ((a >> (e + 1)) != 0) e++;
    man = 23'((a << (23 - e)) & 32'h007F_FFFF);
    return {s, 8'(127 + e), man};
  endfunction

  function automatic logic [2*OB-1:0] romWord(input int k);
    return {floatOf(k), floatOf(-k)};
  endfunction

  // ROM with LAT cycles of read latency
  always @(posedge clk) begin
    romPipe[0] <= romWord(int'(romAddr));
    for (int k = 1; k < LAT; k++) romPipe[k] <= romPipe[k-1];
  end
  assign romData = romPipe[LAT-1];

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One full run with optional stall window and a mid-run start/mode poke
  task automatic applyStimulus(input string name, input bit fwd, input int stallAt,
                               input int stallLen, input int pokeAt,
                               input int expFirst, input int expDone);
    logic [31:0] eRe [64];
    logic [31:0] eIm [64];
    int          eM  [64];
    logic        eLast [64];
    int nExp, k, firstCyc, doneCyc, gaps, m, a;
    bit negRe;
    nExp = 0;
    m = fwd ? 2 : N;
    while (m >= 2 && m <= N) begin
      for (int i = 0; i < m; i++) begin
        negRe = (i >= m/2);
        a = negRe ? (m/2 - 1) + (m - 1 - i) : (m/2 - 1) + i;
        eRe[nExp]   = floatOf(a)  ^ {negRe, 31'b0};
        eIm[nExp]   = floatOf(-a) ^ {!fwd, 31'b0};
        eM[nExp]    = m;
        eLast[nExp] = (i == m - 1);
        nExp++;
      end
      m = fwd ? m * 2 : m / 2;
    end
    k = 0; firstCyc = -1; doneCyc = -1; gaps = 0;
    @(negedge clk);
    isFwd = fwd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400 && doneCyc < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) checkOutput({name, "_busy_at_accept"}, busy, 1);
      if (twValid) begin
        if (firstCyc < 0) firstCyc = c;
        if (k < nExp) begin
          checkOutput($sformatf("%s_re%0d", name, k), twReal, eRe[k]);
          checkOutput($sformatf("%s_im%0d", name, k), twImag, eIm[k]);
          checkOutput($sformatf("%s_m%0d", name, k), twM, eM[k]);
          checkOutput($sformatf("%s_last%0d", name, k), twLast, eLast[k]);
        end else begin
          checkOutput({name, "_extra_beat"}, k, nExp);
        end
        k++;
      end else if (firstCyc >= 0 && k < nExp) begin
        gaps++;
      end
      if (done) doneCyc = c;
      stall = (c >= stallAt && c < stallAt + stallLen);
      if (c == pokeAt) begin
        start = 1'b1;
        isFwd = !fwd;
      end else begin
        start = 1'b0;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    checkOutput({name, "_first_valid_cycle"}, firstCyc, expFirst);
    checkOutput({name, "_done_cycle"}, doneCyc, expDone);
    checkOutput({name, "_beats"}, k, 2*N - 2);
    checkOutput({name, "_gap_cycles"}, gaps, stallLen);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput({name, "_idle_valid"}, twValid, 0);
      checkOutput({name, "_idle_busy"}, busy, 0);
      checkOutput({name, "_idle_done"}, done, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    isFwd = 1'b1;
    stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", twValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_addr", romAddr, 0);
    checkOutput("rst_real", twReal, 0);
    checkOutput("rst_imag", twImag, 0);
    checkOutput("rst_m", twM, 0);
    checkOutput("rst_last", twLast, 0);

    // Plain forward run, then spot checks of hand-encoded beats
    applyStimulus("fwd", 1'b1, -10, 0, -10, 12, 42);
    // Plain inverse run
    applyStimulus("inv", 1'b0, -10, 0, -10, 4, 34);
    // Forward with 3-cycle stall inside m=8, start poke and mode toggle mid-run
    applyStimulus("fwd_stall", 1'b1, 17, 3, 25, 12, 45);

    // Reset in the middle of a forward run
    @(negedge clk);
    isFwd = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midrst_pre_valid", twValid, 1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", twValid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("postrst_valid", twValid, 0);
      checkOutput("postrst_busy", busy, 0);
      checkOutput("postrst_done", done, 0);
    end
    applyStimulus("replay", 1'b1, -10, 0, -10, 12, 42);

    // Hand-encoded reference words used by the streams above
    checkOutput("enc_one", floatOf(1), 32'h3F80_0000);
    checkOutput("enc_neg_two", floatOf(-2), 32'hC000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Spot checks of specific forward beats against hand-computed words
  initial begin : spot
    int beat;
    beat = 0;
    @(negedge rst);
    @(posedge start);
    while (beat < 6) begin
      @(negedge clk);
      if (twValid) begin
        case (beat)
          0: checkOutput("spot_b0_re", twReal, 32'h0000_0000);
          1: checkOutput("spot_b1_re", twReal, 32'h8000_0000);
          2: checkOutput("spot_b2_im", twImag, 32'hBF80_0000);
          3: checkOutput("spot_b3_re", twReal, 32'h4000_0000);
          4: checkOutput("spot_b4_re", twReal, 32'hC000_0000);
          5: checkOutput("spot_b5_re", twReal, 32'hBF80_0000);
          default: ;
        endcase
        beat++;
      end
    end
  end

endmodule
